// File: rtl/rvc_compress_packer_pkg.sv
// Shared RV32I / RVC encoding constants and packer types.
package rvc_compress_packer_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned CLEN = 16;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // RV32I funct3 / funct7
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [6:0] F7_ADD  = 7'b0000000;

    // RVC quadrants
    localparam logic [1:0] RVC_Q0 = 2'b00;
    localparam logic [1:0] RVC_Q1 = 2'b01;
    localparam logic [1:0] RVC_Q2 = 2'b10;

    // RVC funct3 / funct4
    localparam logic [2:0] CF3_ADDI = 3'b000;
    localparam logic [2:0] CF3_LI   = 3'b010;
    localparam logic [2:0] CF3_LW   = 3'b010;
    localparam logic [2:0] CF3_SW   = 3'b110;
    localparam logic [3:0] CF4_MV   = 4'b1000;
    localparam logic [3:0] CF4_ADD  = 4'b1001;

    localparam logic [CLEN-1:0] C_NOP    = 16'h0001;
    localparam logic [XLEN-1:0] RV_NOP   = 32'h00000013;

    // Packer state: a lower halfword is held waiting for its partner
    typedef enum logic {
        PK_EMPTY = 1'b0,
        PK_HALF  = 1'b1
    } pack_state_e;

    // True for the x8..x15 registers reachable by 3-bit RVC register fields
    function automatic logic is_creg(input logic [4:0] r);
        return (r[4:3] == 2'b01);
    endfunction

endpackage

// File: rtl/rvc_encoder.sv
// Combinational RV32I -> RVC re-encoder for the supported subset.
module rvc_encoder
    import rvc_compress_packer_pkg::*;
#(
    parameter bit COMPRESS_EN = 1'b1
) (
    input  logic [XLEN-1:0] instr,
    output logic            is_comp_c,
    output logic [CLEN-1:0] c16_c
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic        imm6_ok;
    logic        is_addi;
    logic        is_add;
    logic        lw_ok;
    logic        sw_ok;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];
    assign imm_i  = instr[31:20];
    assign imm_s  = {instr[31:25], instr[11:7]};

    // Immediate fits a signed 6-bit field when bits 11..5 are all copies of bit 5
    assign imm6_ok = (imm_i[11:5] == {7{imm_i[5]}});
    assign is_addi = (opcode == OPC_OP_IMM) && (f3 == F3_ADDI);
    assign is_add  = (opcode == OPC_OP) && (f3 == F3_ADD) && (f7 == F7_ADD);
    // Word-aligned offset in 0..124 with both registers in x8..x15
    assign lw_ok   = (opcode == OPC_LOAD) && (f3 == F3_LW) && is_creg(rd) && is_creg(rs1)
                     && (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0);
    assign sw_ok   = (opcode == OPC_STORE) && (f3 == F3_SW) && is_creg(rs2) && is_creg(rs1)
                     && (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0);

    // Priority-ordered match of the compressible forms
    always_comb begin
        is_comp_c = 1'b0;
        c16_c     = '0;
        if (COMPRESS_EN) begin
            if (instr == RV_NOP) begin
                is_comp_c = 1'b1;
                c16_c     = C_NOP;
            end else if (is_addi && (rd != 5'd0) && (rs1 == 5'd0) && imm6_ok) begin
                is_comp_c = 1'b1;
                c16_c     = {CF3_LI, imm_i[5], rd, imm_i[4:0], RVC_Q1};
            end else if (is_addi && (rd != 5'd0) && (rs1 == rd) && (imm_i != 12'd0) && imm6_ok) begin
                is_comp_c = 1'b1;
                c16_c     = {CF3_ADDI, imm_i[5], rd, imm_i[4:0], RVC_Q1};
            end else if (is_add && (rd != 5'd0) && (rs2 != 5'd0) && (rs1 == 5'd0)) begin
                is_comp_c = 1'b1;
                c16_c     = {CF4_MV, rd, rs2, RVC_Q2};
            end else if (is_add && (rd != 5'd0) && (rs2 != 5'd0) && (rs1 == rd)) begin
                is_comp_c = 1'b1;
                c16_c     = {CF4_ADD, rd, rs2, RVC_Q2};
            end else if (lw_ok) begin
                is_comp_c = 1'b1;
                c16_c     = {CF3_LW, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], RVC_Q0};
            end else if (sw_ok) begin
                is_comp_c = 1'b1;
                c16_c     = {CF3_SW, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], RVC_Q0};
            end
        end
    end

endmodule

// File: rtl/rvc_compress_packer.sv
// Compresses RV32I instructions where possible and packs 16/32-bit parcels
// little-endian into 32-bit memory words; 32-bit parcels may straddle words.
module rvc_compress_packer
    import rvc_compress_packer_pkg::*;
#(
    parameter bit          COMPRESS_EN = 1'b1,
    parameter logic [15:0] PAD_HALF    = 16'h0001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    output logic            inReady,
    input  logic [XLEN-1:0] inInstr,
    input  logic            flush,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] outWord,
    output logic            busy,
    output logic [15:0]     compCount
);

    pack_state_e     state;
    pack_state_e     state_nxt;
    logic [CLEN-1:0] hold_half;
    logic [CLEN-1:0] hold_half_nxt;
    logic [XLEN-1:0] out_word_nxt;
    logic            out_valid_nxt;
    logic [15:0]     comp_count_nxt;
    logic            is_comp;
    logic [CLEN-1:0] c16;
    logic            in_xfer;
    logic            flush_fire;

    rvc_encoder #(
        .COMPRESS_EN (COMPRESS_EN)
    ) u_encoder (
        .instr     (inInstr),
        .is_comp_c (is_comp),
        .c16_c     (c16)
    );

    // Single output register without skid: accept only when it will be free
    assign inReady    = !outValid || outReady;
    assign in_xfer    = inValid && inReady;
    assign flush_fire = flush && !inValid && (state == PK_HALF) && inReady;
    assign busy       = (state == PK_HALF) || outValid;

    // State, held halfword, output register and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PK_EMPTY;
            hold_half <= '0;
            outWord   <= '0;
            outValid  <= 1'b0;
            compCount <= '0;
        end else begin
            state     <= state_nxt;
            hold_half <= hold_half_nxt;
            outWord   <= out_word_nxt;
            outValid  <= out_valid_nxt;
            compCount <= comp_count_nxt;
        end
    end

    // Next state: a halfword toggles the parity, a full word keeps it
    always_comb begin
        state_nxt = state;
        if (in_xfer) begin
            if (is_comp) begin
                state_nxt = (state == PK_EMPTY) ? PK_HALF : PK_EMPTY;
            end
        end else if (flush_fire) begin
            state_nxt = PK_EMPTY;
        end
    end

    // Next output register, held halfword and counter values
    always_comb begin
        hold_half_nxt  = hold_half;
        out_word_nxt   = outWord;
        out_valid_nxt  = outValid && !outReady;
        comp_count_nxt = compCount;
        if (in_xfer) begin
            comp_count_nxt = compCount + 16'(is_comp);
            if (state == PK_EMPTY) begin
                if (is_comp) begin
                    hold_half_nxt = c16;
                end else begin
                    out_word_nxt  = inInstr;
                    out_valid_nxt = 1'b1;
                end
            end else begin
                out_valid_nxt = 1'b1;
                if (is_comp) begin
                    out_word_nxt = {c16, hold_half};
                end else begin
                    out_word_nxt  = {inInstr[15:0], hold_half};
                    hold_half_nxt = inInstr[31:16];
                end
            end
        end else if (flush_fire) begin
            out_word_nxt  = {PAD_HALF, hold_half};
            out_valid_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_rvc_compress_packer.sv
// Directed bench for rvc_compress_packer: encoder table plus packing,
// backpressure, reset and no-compress sequences.
module tb_rvc_compress_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [31:0] in_instr, out_word;
    logic [15:0] comp_count;

    logic        nc_in_valid, nc_in_ready, nc_flush, nc_out_valid, nc_out_ready, nc_busy;
    logic [31:0] nc_in_instr, nc_out_word;
    logic [15:0] nc_comp_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] got_q[$];
    logic [31:0] nc_q[$];
    logic        nc_hold_seen = 1'b0;
    int unsigned exp_comp = 0;

    typedef struct {
        logic [31:0] instr;
        logic        is_c;
        logic [31:0] word;
    } vec_t;
    vec_t vecs[14];

    always #5 clk = ~clk;

    rvc_compress_packer #(.COMPRESS_EN(1'b1), .PAD_HALF(16'h0001)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(in_ready),
        .inInstr(in_instr), .flush(flush), .outValid(out_valid), .outReady(out_ready),
        .outWord(out_word), .busy(busy), .compCount(comp_count)
    );

    rvc_compress_packer #(.COMPRESS_EN(1'b0), .PAD_HALF(16'h0001)) dut_nc (
        .clk(clk), .rst_n(rst_n), .inValid(nc_in_valid), .inReady(nc_in_ready),
        .inInstr(nc_in_instr), .flush(nc_flush), .outValid(nc_out_valid), .outReady(nc_out_ready),
        .outWord(nc_out_word), .busy(nc_busy), .compCount(nc_comp_count)
    );

    // Collect transferred words; inputs only change at negedge or just after posedge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back(out_word);
        if (rst_n && nc_out_valid && nc_out_ready) nc_q.push_back(nc_out_word);
        if (rst_n && nc_busy && !nc_out_valid) nc_hold_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic send(input logic [31:0] instr);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = instr;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic nc_send(input logic [31:0] instr);
        int n = 0;
        @(negedge clk);
        nc_in_valid = 1'b1;
        nc_in_instr = instr;
        while (!nc_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!nc_in_ready) check("nc_send_timeout", 32'(nc_in_ready), 32'd1);
        @(posedge clk);
        #1 nc_in_valid = 1'b0;
    endtask

    task automatic do_flush();
        int n = 0;
        @(negedge clk);
        flush = 1'b1;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        flush = 1'b0;
        if (busy) check("flush_timeout", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] q_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 32'hxxxxxxxx;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h00148493, 1'b1, 32'h00010485};  // addi x9,x9,1   -> C.ADDI
        vecs[1]  = '{32'h00000013, 1'b1, 32'h00010001};  // nop            -> C.NOP
        vecs[2]  = '{32'hFFF00293, 1'b1, 32'h000152FD};  // addi x5,x0,-1  -> C.LI
        vecs[3]  = '{32'h02048493, 1'b0, 32'h02048493};  // addi x9,x9,32  out of range
        vecs[4]  = '{32'hFE048493, 1'b1, 32'h00011481};  // addi x9,x9,-32 -> C.ADDI
        vecs[5]  = '{32'h00048493, 1'b0, 32'h00048493};  // addi x9,x9,0   zero imm
        vecs[6]  = '{32'h006002B3, 1'b1, 32'h0001829A};  // add x5,x0,x6   -> C.MV
        vecs[7]  = '{32'h006282B3, 1'b1, 32'h0001929A};  // add x5,x5,x6   -> C.ADD
        vecs[8]  = '{32'h00852483, 1'b1, 32'h00014504};  // lw x9,8(x10)   -> C.LW
        vecs[9]  = '{32'h08952023, 1'b0, 32'h08952023};  // sw x9,128(x10) out of range
        vecs[10] = '{32'h06952E23, 1'b1, 32'h0001DD64};  // sw x9,124(x10) -> C.SW
        vecs[11] = '{32'h00052803, 1'b0, 32'h00052803};  // lw x16,0(x10)  rd not x8..x15
        vecs[12] = '{32'h00652483, 1'b0, 32'h00652483};  // lw x9,6(x10)   misaligned
        vecs[13] = '{32'h00600033, 1'b0, 32'h00600033};  // add x0,x0,x6   rd=0

        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
        nc_in_valid = 1'b0; nc_in_instr = '0; nc_flush = 1'b0; nc_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_word", out_word, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_comp_count", 32'(comp_count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Each instruction alone, then flush: a compressed one comes out padded
        for (int i = 0; i < 14; i++) begin
            got_q.delete();
            send(vecs[i].instr);
            do_flush();
            repeat (2) @(negedge clk);
            if (vecs[i].is_c) exp_comp++;
            check($sformatf("vec%0d_nwords", i), 32'(got_q.size()), 32'd1);
            check($sformatf("vec%0d_word", i), q_at(0), vecs[i].word);
            check($sformatf("vec%0d_comp_count", i), 32'(comp_count), 32'(exp_comp[15:0]));
        end

        // Straddling 32-bit parcel after a halfword, then flush the upper half
        got_q.delete();
        send(32'h00148493);
        send(32'h123450B7);
        do_flush();
        repeat (2) @(negedge clk);
        exp_comp += 1;
        check("straddle_nwords", 32'(got_q.size()), 32'd2);
        check("straddle_word0", q_at(0), 32'h50B70485);
        check("straddle_word1", q_at(1), 32'h00011234);
        check("straddle_comp_count", 32'(comp_count), 32'(exp_comp[15:0]));

        // Two halfwords pair into one word without a flush
        got_q.delete();
        send(32'h00000013);
        send(32'h00000013);
        repeat (3) @(negedge clk);
        exp_comp += 2;
        check("nop_pair_nwords", 32'(got_q.size()), 32'd1);
        check("nop_pair_word", q_at(0), 32'h00010001);
        check("nop_pair_busy", 32'(busy), 32'd0);
        check("nop_pair_comp_count", 32'(comp_count), 32'(exp_comp[15:0]));

        // Backpressure: output stalls for 5 cycles with the next input waiting
        got_q.delete();
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'h123450B7);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 32'h00852483;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_out_word", k), out_word, 32'h123450B7);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        send(32'h00000013);
        repeat (3) @(negedge clk);
        exp_comp += 2;
        check("stall_nwords", 32'(got_q.size()), 32'd2);
        check("stall_word0", q_at(0), 32'h123450B7);
        check("stall_word1", q_at(1), 32'h00014504);
        check("stall_comp_count", 32'(comp_count), 32'(exp_comp[15:0]));

        // Reset while a halfword is held discards it
        got_q.delete();
        send(32'h00148493);
        @(negedge clk);
        check("half_busy", 32'(busy), 32'd1);
        check("half_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_comp_count", 32'(comp_count), 32'd0);
        rst_n = 1'b1;
        exp_comp = 0;
        send(32'h00000013);
        send(32'h00000013);
        repeat (3) @(negedge clk);
        exp_comp += 2;
        check("postreset_nwords", 32'(got_q.size()), 32'd1);
        check("postreset_word", q_at(0), 32'h00010001);
        check("postreset_comp_count", 32'(comp_count), 32'(exp_comp[15:0]));

        // Compression disabled: plain 32-bit passthrough, never holds a halfword
        nc_q.delete();
        nc_hold_seen = 1'b0;
        nc_send(32'h00148493);
        nc_send(32'h123450B7);
        repeat (3) @(negedge clk);
        check("nc_nwords", 32'(nc_q.size()), 32'd2);
        check("nc_word0", (nc_q.size() > 0) ? nc_q[0] : 32'hxxxxxxxx, 32'h00148493);
        check("nc_word1", (nc_q.size() > 1) ? nc_q[1] : 32'hxxxxxxxx, 32'h123450B7);
        check("nc_hold_seen", 32'(nc_hold_seen), 32'd0);
        check("nc_busy", 32'(nc_busy), 32'd0);
        check("nc_comp_count", 32'(nc_comp_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
